opfetch_unit: RTL and testbench
===============================

# opfetch_unit

Operand-fetch and writeback sequencer that sits directly upstream of `regfile`, on both its read and write sides. It accepts decoded instructions carrying up to two source indices, fetches each operand through the register file's level `re`/`rack` handshake, and presents both operands to execute with a valid/ready handshake. It also accepts writeback requests and drives the register file's `we`/`wack` handshake. It orders a read behind any in-flight write to the same register.

## Interface
- `REG_SZ`, 32, operand and data width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: unit can accept an instruction.
- `in_rs`, `in_rt` in 5: source register indices.
- `op_valid` out 1: operands valid.
- `op_ready` in 1: execute accepts the operands.
- `op_a`, `op_b` out `REG_SZ`: operand values for `rs` and `rt`.
- `wb_valid` in 1: writeback request.
- `wb_ready` out 1: one-cycle pulse when the writeback is retired.
- `wb_idx` in 5: writeback destination index.
- `wb_data` in `REG_SZ`: writeback data.
- `r_idx` out 5, `re` out 1, `rack` in 1, `dout` in `REG_SZ`: register file read port.
- `w_idx` out 5, `we` out 1, `wack` in 1, `din` out `REG_SZ`: register file write port.

## Operation
- Read FSM states: `IDLE`, `RA_REQ`, `RA_REL`, `RB_REQ`, `RB_REL`, `OUT`.
- `IDLE`: `in_ready=1`.
  - On `in_valid`, latch `rs` and `rt`, then go to `RA_REQ`.
- `RA_REQ`:
  - If `rs==0`: `op_a=0` and go to `RB_REQ` with no handshake.
  - If the write FSM is busy with `w_idx==rs`: stall with `re` held at 0.
  - Otherwise drive `r_idx=rs` and `re=1`.
  - When `rack==1` is sampled: capture `dout` into `op_a`, drive `re=0`, go to `RA_REL`.
- `RA_REL`: wait for `rack==0`, then go to `RB_REQ`.
- `RB_REQ` and `RB_REL` mirror `RA_REQ` and `RA_REL` for `rt`, writing `op_b`. `RB_REL` exits to `OUT`.
- `OUT`: `op_valid=1`; `op_a` and `op_b` are held stable.
  - On `op_ready`, go to `IDLE`.
  - `in_ready` stays 0 throughout `OUT`; there is no same-cycle re-accept.
- Write FSM states: `W_IDLE`, `W_REQ`, `W_REL`.
- `W_IDLE`:
  - On `wb_valid` with `wb_idx!=0`: latch `wb_idx` and `wb_data` to `w_idx` and `din`, then go to `W_REQ`.
  - On `wb_valid` with `wb_idx==0`: pulse `wb_ready` and stay in `W_IDLE`; `we` is never asserted.
- `W_REQ`: `we=1`. When `wack==1` is sampled, drive `we=0` and go to `W_REL`.
- `W_REL`: when `wack==0` is sampled, pulse `wb_ready` and go to `W_IDLE`.
- `wb_valid` must be held until `wb_ready`. It is ignored outside `W_IDLE`.
- Both FSMs run concurrently. The read-stall check is the only interaction between them.
- The write FSM is busy in `W_REQ` and `W_REL`, and for the first cycle of a new latch.
- `rack` and `wack` are sampled on `clk` without a synchronizer. The register file's handshake outputs must be stable across clock edges.

## Timing
- Reset values:
  - `in_ready=0` during reset, 1 in the cycle after reset.
  - `op_valid=0`, `op_a=0`, `op_b=0`.
  - `re=0`, `we=0`, `r_idx=0`, `w_idx=0`, `din=0`, `wb_ready=0`.
  - Both FSMs in their idle state.
- All outputs are registered.
- Read latency with an immediately responding register file: 2 cycles per handshake (REQ then REL), 1 cycle per zero-index operand.
  - Two non-zero sources: `op_valid` is high 5 cycles after the accept edge.
  - Both sources zero: 3 cycles.
- Write retirement takes at least 3 cycles from `wb_valid` to `wb_ready`.
- `re` never rises while `rack==1`. `we` never rises while `wack==1`.
- Reset asserted mid-handshake forces `re` and `we` low immediately (asynchronously) and discards any partial operands.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - In `RA_REQ`/`RB_REQ`, if the write FSM is busy with the same non-zero index, the operand takes the latched `din` value.
  - The read FSM then advances as in the zero-index path: no stall, no read handshake.
- `OPFETCH_BYPASS_EN` undefined: the read stalls until the write FSM returns to `W_IDLE`, then performs a normal read.

## Test plan
- Reset, then `rs=3`, `rt=5`, with the register file preloaded to 3→7 and 5→9 -> `op_a=7`, `op_b=9`, `op_valid` at cycle 5, two `re` pulses with `r_idx` 3 then 5.
- `rs=0`, `rt=0` -> `op_a=0`, `op_b=0`, no `re` activity, `op_valid` at cycle 3.
- `wb_idx=4`, `wb_data=0x1234` -> one `we` pulse with `w_idx=4`, `din=0x1234`; a later read of r4 returns `0x1234`.
- `wb_idx=0`, `wb_data=0xFFFF` -> `wb_ready` pulses after 1 cycle, no `we`, r0 still reads 0.
- `wb_idx=6`, value 42, with the register file holding `wack` low for 4 cycles, and `rs=6` issued at the same time:
  - Without `OPFETCH_BYPASS_EN`: `re` stays low until the write retires, then `op_a=42`.
  - With `OPFETCH_BYPASS_EN`: `op_a=42` and no `r_idx=6` handshake.
- Reset asserted during `RB_REQ` with `re=1` -> `re=0` the same cycle, `op_valid=0`, and `in_ready=1` after release.

Source files
------------

// File: rtl/opfetch_unit.sv
// opfetch_unit: operand-fetch and writeback sequencer in front of regfile.
//
// Two independent FSMs share one hazard check:
//   read FSM  : accepts an instruction (rs, rt), fetches each non-zero source
//               over the level re/rack handshake and presents op_a/op_b with
//               op_valid/op_ready.
//   write FSM : accepts a writeback (wb_idx, wb_data) and drives the level
//               we/wack handshake, pulsing wb_ready on retirement.
// A read of a register with a pending write either stalls until the write
// retires or, with OPFETCH_BYPASS_EN defined, takes the pending data directly.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         instruction handshake; in_rs/in_rt source indices
//   op_valid/op_ready         operand handshake; op_a/op_b operand values
//   wb_valid/wb_ready         writeback request / retire pulse; wb_idx, wb_data
//   r_idx, re, rack, dout     register file read port
//   w_idx, we, wack, din      register file write port
//
// Build option: OPFETCH_BYPASS_EN (forward pending write data to the reader).

module opfetch_unit #(
    parameter int REG_SZ = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [REG_SZ-1:0] op_a,
    output logic [REG_SZ-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [4:0]        wb_idx,
    input  logic [REG_SZ-1:0] wb_data,
    output logic [4:0]        r_idx,
    output logic              re,
    input  logic              rack,
    input  logic [REG_SZ-1:0] dout,
    output logic [4:0]        w_idx,
    output logic              we,
    input  logic              wack,
    output logic [REG_SZ-1:0] din
);

    typedef enum logic [2:0] {IDLE, RA_REQ, RA_REL, RB_REQ, RB_REL, OUT} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_REL} wr_state_t;

    rd_state_t r_state;
    wr_state_t w_state;
    logic [4:0] rs_q, rt_q;

    // Pending-write view seen by the reader. A writeback being latched this
    // very cycle already counts, so a read accepted on the same edge as a
    // write to the same register is ordered behind it.
    logic       w_busy, pend_vld;
    logic [4:0] pend_idx;

    always_comb begin
        w_busy   = (w_state != W_IDLE);
        pend_vld = w_busy || (wb_valid && !wb_ready && (wb_idx != 5'd0));
        pend_idx = w_busy ? w_idx : wb_idx;
    end

`ifdef OPFETCH_BYPASS_EN
    logic [REG_SZ-1:0] pend_dat;
    assign pend_dat = w_busy ? din : wb_data;
`endif

    function automatic logic wr_hit(input logic [4:0] idx);
        return pend_vld && (idx != 5'd0) && (idx == pend_idx);
    endfunction

    // re is registered, so it is raised on the edge that enters a REQ state
    // to keep a handshake at two cycles. Never raise it while rack is high.
    function automatic logic can_issue(input logic [4:0] idx);
        return (idx != 5'd0) && !wr_hit(idx) && !rack;
    endfunction

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            in_ready <= 1'b0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            r_idx    <= '0;
            re       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rs_q     <= in_rs;
                        rt_q     <= in_rt;
                        in_ready <= 1'b0;
                        r_idx    <= in_rs;
                        re       <= can_issue(in_rs);
                        r_state  <= RA_REQ;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RA_REQ: begin
                    if (re) begin
                        if (rack) begin
                            op_a    <= dout;
                            re      <= 1'b0;
                            r_state <= RA_REL;
                        end
                    end else if (rs_q == 5'd0) begin
                        op_a    <= '0;
                        r_idx   <= rt_q;
                        re      <= can_issue(rt_q);
                        r_state <= RB_REQ;
                    end
`ifdef OPFETCH_BYPASS_EN
                    else if (wr_hit(rs_q)) begin
                        op_a    <= pend_dat;
                        r_idx   <= rt_q;
                        re      <= can_issue(rt_q);
                        r_state <= RB_REQ;
                    end
`endif
                    else if (can_issue(rs_q)) begin
                        re <= 1'b1;  // stall released
                    end
                end
                RA_REL: begin
                    if (!rack) begin
                        r_idx   <= rt_q;
                        re      <= can_issue(rt_q);
                        r_state <= RB_REQ;
                    end
                end
                RB_REQ: begin
                    if (re) begin
                        if (rack) begin
                            op_b    <= dout;
                            re      <= 1'b0;
                            r_state <= RB_REL;
                        end
                    end else if (rt_q == 5'd0) begin
                        op_b     <= '0;
                        op_valid <= 1'b1;
                        r_state  <= OUT;
                    end
`ifdef OPFETCH_BYPASS_EN
                    else if (wr_hit(rt_q)) begin
                        op_b     <= pend_dat;
                        op_valid <= 1'b1;
                        r_state  <= OUT;
                    end
`endif
                    else if (can_issue(rt_q)) begin
                        re <= 1'b1;
                    end
                end
                RB_REL: begin
                    if (!rack) begin
                        op_valid <= 1'b1;
                        r_state  <= OUT;
                    end
                end
                OUT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        in_ready <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            w_idx    <= '0;
            din      <= '0;
            we       <= 1'b0;
            wb_ready <= 1'b0;
        end else begin
            wb_ready <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    // !wb_ready: the requester may still hold wb_valid in the
                    // cycle of the retire pulse; do not take it twice.
                    if (wb_valid && !wb_ready) begin
                        if (wb_idx == 5'd0) begin
                            wb_ready <= 1'b1;
                        end else begin
                            w_idx   <= wb_idx;
                            din     <= wb_data;
                            we      <= !wack;
                            w_state <= W_REQ;
                        end
                    end
                end
                W_REQ: begin
                    if (we && wack) begin
                        we      <= 1'b0;
                        w_state <= W_REL;
                    end else if (!we && !wack) begin
                        we <= 1'b1;
                    end
                end
                W_REL: begin
                    if (!wack) begin
                        wb_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opfetch_unit.sv
module tb_opfetch_unit;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [4:0]  r_idx, w_idx;
    logic        re, rack, we, wack;
    logic [31:0] dout, din;

    opfetch_unit #(.REG_SZ(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data),
        .r_idx(r_idx), .re(re), .rack(rack), .dout(dout),
        .w_idx(w_idx), .we(we), .wack(wack), .din(din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: reads answer immediately, writes acknowledge after
    // wdelay cycles of we. Preloaded while reset is held.
    logic [31:0] mem [32];
    int wcnt;
    int wdelay;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h100 + i;
            mem[0] <= 32'd0;
            mem[3] <= 32'd7;
            mem[5] <= 32'd9;
        end else if (we && wack) begin
            mem[w_idx] <= din;
        end
        if (we) wcnt <= wcnt + 1; else wcnt <= 0;
    end
    assign rack = re;
    assign dout = (r_idx == 5'd0) ? 32'd0 : mem[r_idx];
    assign wack = we && (wcnt >= wdelay);

    // Handshake monitors
    logic [4:0]  re_log[$];
    logic [4:0]  we_idx_log[$];
    logic [31:0] we_dat_log[$];
    bit re_prev, we_prev;
    always @(negedge clk) begin
        if (re && !re_prev) re_log.push_back(r_idx);
        if (we && !we_prev) begin
            we_idx_log.push_back(w_idx);
            we_dat_log.push_back(din);
        end
        re_prev = re;
        we_prev = we;
    end

    int n_checks, n_err;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one instruction, optionally with a writeback on the same cycle.
    // Called and returns at a negedge. Cycle 1 is the cycle after the accept edge.
    task automatic run_txn(input logic [4:0] rs, input logic [4:0] rt, input bit do_wb,
                           input logic [4:0] widx, input logic [31:0] wdat,
                           output logic [31:0] a, output logic [31:0] b,
                           output int lat, output int wb_cyc, output int re_cyc, output bit ok);
        int cyc;
        bit got_op, got_wb;
        a = '0; b = '0; lat = -1; wb_cyc = -1; re_cyc = -1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        re_log.delete();
        we_idx_log.delete();
        we_dat_log.delete();
        in_valid = 1'b1; in_rs = rs; in_rt = rt;
        if (do_wb) begin wb_valid = 1'b1; wb_idx = widx; wb_data = wdat; end
        got_op = 1'b0; got_wb = !do_wb; cyc = 0;
        while (!(got_op && got_wb) && cyc < 200) begin
            @(negedge clk); cyc++;
            in_valid = 1'b0;
            if (re && re_cyc < 0) re_cyc = cyc;
            if (!got_wb && wb_ready) begin got_wb = 1'b1; wb_cyc = cyc; wb_valid = 1'b0; end
            if (!got_op && op_valid) begin
                got_op = 1'b1; lat = cyc; a = op_a; b = op_b; op_ready = 1'b1;
            end else begin
                op_ready = 1'b0;
            end
        end
        if (op_ready) begin @(negedge clk); op_ready = 1'b0; end
        wb_valid = 1'b0;
        ok = got_op && got_wb;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d, output int cyc);
        we_idx_log.delete();
        we_dat_log.delete();
        wb_valid = 1'b1; wb_idx = idx; wb_data = d;
        cyc = 0;
        while (!wb_ready && cyc < 100) begin @(negedge clk); cyc++; end
        wb_valid = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] a, b;
        int          lat, nre;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] ref_rf[32];
    logic [31:0] a, b;
    int          lat, wbc, rec, wcyc;
    bit          ok;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_rs = '0; in_rt = '0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_idx = '0; wb_data = '0; wdelay = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h100 + i;
        ref_rf[0] = 32'd0; ref_rf[3] = 32'd7; ref_rf[5] = 32'd9;

        vecs[0] = '{rs: 5'd3,  rt: 5'd5, a: 32'd7,     b: 32'd9,     lat: 5, nre: 2};
        vecs[1] = '{rs: 5'd0,  rt: 5'd0, a: 32'd0,     b: 32'd0,     lat: 3, nre: 0};
        vecs[2] = '{rs: 5'd0,  rt: 5'd5, a: 32'd0,     b: 32'd9,     lat: 4, nre: 1};
        vecs[3] = '{rs: 5'd3,  rt: 5'd0, a: 32'd7,     b: 32'd0,     lat: 4, nre: 1};
        vecs[4] = '{rs: 5'd31, rt: 5'd1, a: 32'h11F,   b: 32'h101,   lat: 5, nre: 2};
        vecs[5] = '{rs: 5'd5,  rt: 5'd5, a: 32'd9,     b: 32'd9,     lat: 5, nre: 2};

        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset op_valid", op_valid, 0);
        chk("reset op_a", op_a, 0);
        chk("reset op_b", op_b, 0);
        chk("reset re/we", {re, we}, 0);
        chk("reset r_idx/w_idx", {r_idx, w_idx}, 0);
        chk("reset din", din, 0);
        chk("reset wb_ready", wb_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);

        // Table of plain reads against the preloaded register file
        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].rs, vecs[v].rt, 1'b0, 5'd0, 32'd0, a, b, lat, wbc, rec, ok);
            chk($sformatf("vec%0d done", v), ok, 1);
            chk($sformatf("vec%0d op_a", v), a, vecs[v].a);
            chk($sformatf("vec%0d op_b", v), b, vecs[v].b);
            chk($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            chk($sformatf("vec%0d re pulses", v), re_log.size(), vecs[v].nre);
            if (v == 0) begin
                chk("vec0 first r_idx", (re_log.size() > 0) ? re_log[0] : 5'd0, 3);
                chk("vec0 second r_idx", (re_log.size() > 1) ? re_log[1] : 5'd0, 5);
            end
        end

        // Writeback to r4, then read it back
        wr(5'd4, 32'h1234, wcyc);
        ref_rf[4] = 32'h1234;
        chk("wb r4 retire cycles", wcyc, 3);
        chk("wb r4 we pulses", we_idx_log.size(), 1);
        chk("wb r4 w_idx", (we_idx_log.size() > 0) ? we_idx_log[0] : 5'd0, 4);
        chk("wb r4 din", (we_dat_log.size() > 0) ? we_dat_log[0] : 32'd0, 32'h1234);
        run_txn(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, a, b, lat, wbc, rec, ok);
        chk("read r4", a, 32'h1234);

        // Writeback to r0 is retired without touching the register file
        wr(5'd0, 32'hFFFF, wcyc);
        chk("wb r0 retire cycles", wcyc, 1);
        chk("wb r0 no we", we_idx_log.size(), 0);
        run_txn(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, a, b, lat, wbc, rec, ok);
        chk("read r0", a, 0);

        // Read of r6 on the same cycle as a slow writeback to r6
        wdelay = 4;
        ref_rf[6] = 32'd42;
        run_txn(5'd6, 5'd0, 1'b1, 5'd6, 32'd42, a, b, lat, wbc, rec, ok);
        chk("hazard done", ok, 1);
        chk("hazard op_a", a, 42);
        chk("hazard op_b", b, 0);
`ifdef OPFETCH_BYPASS_EN
        chk("bypass no re", re_log.size(), 0);
`else
        chk("stall re after retire", (rec > wbc) && (wbc > 0), 1);
        chk("stall one re for r6", (re_log.size() == 1) && (re_log[0] == 5'd6), 1);
`endif
        wdelay = 0;

        // Randomized reads with occasional concurrent writebacks
        for (int n = 0; n < 30; n++) begin
            logic [4:0]  rs, rt, widx;
            logic [31:0] wd;
            bit          dw;
            rs = 5'($urandom_range(31));
            rt = 5'($urandom_range(31));
            widx = 5'($urandom_range(31));
            wd = $urandom;
            dw = ($urandom_range(2) == 0);
            wdelay = $urandom_range(3);
            if (dw && widx != 5'd0) ref_rf[widx] = wd;
            run_txn(rs, rt, dw, widx, wd, a, b, lat, wbc, rec, ok);
            chk($sformatf("rand%0d done", n), ok, 1);
            chk($sformatf("rand%0d op_a r%0d", n, rs), a, ref_rf[rs]);
            chk($sformatf("rand%0d op_b r%0d", n, rt), b, ref_rf[rt]);
        end
        wdelay = 0;

        // Reset asserted while the rt read request is up
        @(negedge clk);
        in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd5;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rb_req re", re, 1);
        chk("rb_req r_idx", r_idx, 5);
        rst = 1'b1;
        #1;
        chk("async reset re", re, 0);
        chk("async reset op_valid", op_valid, 0);
        chk("async reset op_a", op_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after mid reset", in_ready, 1);
        chk("op_valid after mid reset", op_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
